// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared mode encodings, FSM states and nominal PWM profile constants
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_A    = 2'b01;
    localparam logic [1:0] MODE_B    = 2'b10;

    // Nominal profiles, also used by the PWM generator side of the link
    localparam int DEF_A_PERIOD = 501;
    localparam int DEF_A_HIGH   = 301;
    localparam int DEF_B_PERIOD = 626;
    localparam int DEF_B_HIGH   = 226;
    localparam int DEF_TOL      = 4;
    localparam int DEF_TIMEOUT  = 4096;

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - 2-flop synchroniser for the PWM pin plus rise/fall detection
module pwm_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            prev   <= 1'b0;
        end else begin
            meta   <= pwm_in;
            sync_q <= meta;
            prev   <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev;
    assign fall = ~sync_q & prev;

endmodule

// File: rtl/pwm_decode.sv
// rtl/pwm_decode.sv - measures PWM period/high time and classifies it as mode A or B
module pwm_decode
    import pwm_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int A_PERIOD = DEF_A_PERIOD,
    parameter int A_HIGH   = DEF_A_HIGH,
    parameter int B_PERIOD = DEF_B_PERIOD,
    parameter int B_HIGH   = DEF_B_HIGH,
    parameter int TOL      = DEF_TOL,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic [1:0]       mode,
    output logic             lost,
    output logic             led0,
    output logic             led1
);

    localparam logic [CNT_W-1:0] A_PER_C   = CNT_W'(A_PERIOD);
    localparam logic [CNT_W-1:0] A_HI_C    = CNT_W'(A_HIGH);
    localparam logic [CNT_W-1:0] B_PER_C   = CNT_W'(B_PERIOD);
    localparam logic [CNT_W-1:0] B_HI_C    = CNT_W'(B_HIGH);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             sync;
    logic             rise;
    logic             fall;
    state_t           state;
    state_t           state_nx;
    logic             take_meas;
    logic             timed_out;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] hi_pend;
    logic             fall_seen;
    logic [CNT_W-1:0] meas_hi;
    logic [1:0]       meas_mode;

    pwm_edge_sync u_edge (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .sync   (sync),
        .rise   (rise),
        .fall   (fall)
    );

    // Extra bit keeps the unsigned difference from wrapping
    function automatic logic near(input logic [CNT_W-1:0] val, input logic [CNT_W-1:0] nom);
        logic [CNT_W:0] diff;
        if (val >= nom)
            diff = {1'b0, val} - {1'b0, nom};
        else
            diff = {1'b0, nom} - {1'b0, val};
        return diff <= {1'b0, TOL_C};
    endfunction

    always_comb begin
        state_nx  = state;
        take_meas = 1'b0;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (rise)
                    state_nx = ARMED;
            end
            ARMED, MEASURE: begin
                // A rise coinciding with the timeout still counts as a measurement
                if (rise) begin
                    state_nx  = MEASURE;
                    take_meas = 1'b1;
                end else if (per_cnt == TIMEOUT_C) begin
                    state_nx  = IDLE;
                    timed_out = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        meas_hi   = fall_seen ? hi_pend : per_cnt;
        meas_mode = MODE_NONE;
        if (near(per_cnt, A_PER_C) && near(meas_hi, A_HI_C))
            meas_mode = MODE_A;
        else if (near(per_cnt, B_PER_C) && near(meas_hi, B_HI_C))
            meas_mode = MODE_B;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            hi_pend    <= '0;
            fall_seen  <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            mode       <= MODE_NONE;
            lost       <= 1'b1;
        end else begin
            state      <= state_nx;
            meas_valid <= take_meas;

            if (rise) begin
                per_cnt   <= CNT_W'(1);
                hi_cnt    <= CNT_W'(1);
                fall_seen <= 1'b0;
            end else if (state == IDLE || timed_out) begin
                per_cnt   <= '0;
                hi_cnt    <= '0;
                fall_seen <= 1'b0;
            end else begin
                if (per_cnt != CNT_MAX)
                    per_cnt <= per_cnt + 1'b1;
                if (sync && hi_cnt != CNT_MAX)
                    hi_cnt <= hi_cnt + 1'b1;
                if (fall) begin
                    hi_pend   <= hi_cnt;
                    fall_seen <= 1'b1;
                end
            end

            if (take_meas) begin
                period    <= per_cnt;
                high_time <= meas_hi;
                mode      <= meas_mode;
                lost      <= 1'b0;
            end else if (timed_out) begin
                mode <= MODE_NONE;
                lost <= 1'b1;
            end
        end
    end

    assign led0 = mode[0];
    assign led1 = mode[1];

endmodule

// File: tb/tb_pwm_decode.sv
// tb/tb_pwm_decode.sv - self-checking bench for pwm_decode with an event-level reference model
module tb_pwm_decode;

    localparam int TIMEOUT = 4096;
    localparam int TOL     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b0;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        meas_valid;
    logic [1:0]  mode;
    logic        lost;
    logic        led0;
    logic        led1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    int v0;

    always #5 clk = ~clk;

    pwm_decode dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .mode       (mode),
        .lost       (lost),
        .led0       (led0),
        .led1       (led1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int near(input int v, input int nom);
        int d;
        d = (v > nom) ? v - nom : nom - v;
        return (d <= TOL) ? 1 : 0;
    endfunction

    function automatic int classify(input int p, input int h);
        if (near(p, 501) != 0 && near(h, 301) != 0) return 1;
        if (near(p, 626) != 0 && near(h, 226) != 0) return 2;
        return 0;
    endfunction

    // Reference model: pin history seen through the 3-cycle detection latency,
    // measurements computed as distances between detected edges.
    bit [3:0] hist = '0;
    int k = 0, j = 0, last_rise = 0, fall_at = 0, phase = 0;
    bit fell = 0;
    int e_period = 0, e_high = 0, e_mode = 0;
    bit e_valid = 0, e_lost = 1;

    always @(posedge clk) begin
        if (rst) begin
            hist = '0; phase = 0; k = 0; fell = 0;
            e_period = 0; e_high = 0; e_mode = 0; e_valid = 0; e_lost = 1;
        end else begin
            k++;
            hist = {hist[2:0], pwm_in};
            j = k - 2;
            e_valid = 0;
            if (hist[2] && !hist[3]) begin
                if (phase != 0) begin
                    e_period = j - last_rise;
                    e_high   = fell ? fall_at - last_rise : e_period;
                    e_mode   = classify(e_period, e_high);
                    e_lost   = 0;
                    e_valid  = 1;
                    phase    = 2;
                end else begin
                    phase = 1;
                end
                last_rise = j;
                fell = 0;
            end else if (phase != 0) begin
                if (!hist[2] && hist[3]) begin
                    fell = 1;
                    fall_at = j;
                end
                if (j - last_rise == TIMEOUT) begin
                    phase = 0; e_lost = 1; e_mode = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("meas_valid", meas_valid, e_valid);
        chk("period", period, e_period);
        chk("high_time", high_time, e_high);
        chk("mode", mode, e_mode);
        chk("lost", lost, e_lost);
        chk("led0", led0, e_mode & 1);
        chk("led1", led1, (e_mode >> 1) & 1);
        if (meas_valid) n_valid++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drive(input int p, input int h);
        pwm_in = 1'b1;
        cyc(h);
        pwm_in = 1'b0;
        cyc(p - h);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        pwm_in = 1'b0;
        cyc(3);
        rst = 1'b0;

        cyc(5000);
        chk("idle_lost", lost, 1);
        chk("idle_mode", mode, 0);
        chk("idle_strobes", n_valid, 0);

        repeat (5) drive(501, 301);
        chk("a_strobes", n_valid, 4);
        chk("a_period", period, 501);
        chk("a_high", high_time, 301);
        chk("a_mode", mode, 1);
        chk("a_led0", led0, 1);
        chk("a_lost", lost, 0);

        v0 = n_valid;
        repeat (3) drive(626, 226);
        chk("b_strobes", n_valid - v0, 3);
        chk("b_period", period, 626);
        chk("b_high", high_time, 226);
        chk("b_mode", mode, 2);
        chk("b_led1", led1, 1);
        chk("b_led0", led0, 0);

        repeat (3) drive(505, 297);
        chk("tol_period", period, 505);
        chk("tol_high", high_time, 297);
        chk("tol_mode", mode, 1);

        v0 = n_valid;
        repeat (2) drive(510, 297);
        chk("off_strobes", n_valid - v0, 2);
        chk("off_period", period, 510);
        chk("off_mode", mode, 0);

        repeat (3) drive(501, 301);
        pwm_in = 1'b1;
        cyc(TIMEOUT + 2);
        chk("stuck_lost_before", lost, 0);
        chk("stuck_mode_before", mode, 1);
        cyc(1);
        chk("stuck_lost", lost, 1);
        chk("stuck_mode", mode, 0);
        chk("stuck_period_hold", period, 501);
        chk("stuck_high_hold", high_time, 301);
        cyc(200);
        pwm_in = 1'b0;
        cyc(50);
        drive(501, 301);
        pwm_in = 1'b1;
        cyc(3);
        chk("restore_valid", meas_valid, 1);
        chk("restore_mode", mode, 1);
        chk("restore_lost", lost, 0);
        cyc(298);
        pwm_in = 1'b0;
        cyc(200);

        repeat (3) drive(626, 226);
        pwm_in = 1'b1;
        cyc(100);
        chk("pre_rst_mode", mode, 2);
        rst = 1'b1;
        #1;
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_mode", mode, 0);
        chk("rst_lost", lost, 1);
        chk("rst_leds", {led1, led0}, 0);
        cyc(1);
        rst = 1'b0;
        v0 = n_valid;
        cyc(126);
        pwm_in = 1'b0;
        cyc(500);
        chk("post_rst_no_strobe", n_valid - v0, 0);
        drive(626, 226);
        chk("post_rst_second_rise", n_valid - v0, 1);
        drive(626, 226);

        drive(4096, 100);
        pwm_in = 1'b1;
        cyc(3);
        chk("edge_valid", meas_valid, 1);
        chk("edge_period", period, 4096);
        chk("edge_high", high_time, 100);
        chk("edge_lost", lost, 0);
        chk("edge_mode", mode, 0);
        cyc(100);
        pwm_in = 1'b0;
        cyc(50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
